ram64_fifo: RTL
===============

# ram64_fifo

Synchronous FIFO controller that turns the 64-word, 16-bit single-port `ram64` into a valid/ready stream buffer. It sits directly upstream of `ram64`, driving its `addr`/`we`/`data_in` and consuming its `data_out`. Pointers, occupancy and a one-word output register live here; the RAM holds the payload. Total capacity is 65 words: 64 in RAM plus 1 in the output register.

## Interface
- `DATA_W`, default 16: word width; must match the RAM.
- `ADDR_W`, default 6: RAM address width. DEPTH = 2**ADDR_W = 64.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `flush` in 1: synchronous clear of FIFO state. RAM contents are not touched.
- `in_data` in DATA_W: push word.
- `in_valid` in 1: push request.
- `in_ready` out 1: push accepted on an edge where `in_valid && in_ready`.
- `out_data` out DATA_W: head word (registered).
- `out_valid` out 1: `out_data` is valid.
- `out_ready` in 1: consumer takes the head on an edge where `out_valid && out_ready`.
- `level` out ADDR_W+1: total words held, 0..65; equals mem_count + `out_valid`.
- `full` out 1: mem_count == DEPTH.
- `empty` out 1: `level` == 0.
- `mem_addr` out ADDR_W: to the RAM `addr`.
- `mem_we` out 1: to the RAM `we`.
- `mem_wdata` out DATA_W: to the RAM `data_in`.
- `mem_rdata` in DATA_W: from the RAM `data_out`. Valid combinationally for `mem_addr` in the same cycle.

## Operation
- State:
  - `wr_ptr` and `rd_ptr`: ADDR_W bits each; wrap 63 -> 0 naturally.
  - `mem_count`: ADDR_W+1 bits, 0..64.
  - `out_valid` and `out_data` registers.
- `pop` = `out_valid && out_ready`.
- `refill` = (mem_count != 0) && (!out_valid || pop) && !flush.
  - The RAM port has one access per cycle. A read (refill) has priority over a write.
- `in_ready` = (mem_count != DEPTH) && !refill && !flush. This is combinational in `out_ready`, `out_valid` and `mem_count`.
- `push` = `in_valid && in_ready`.
- Memory port, all combinational:
  - `mem_addr` = refill ? `rd_ptr` : `wr_ptr`.
  - `mem_we` = `push`.
  - `mem_wdata` = `in_data`.
- On each edge:
  - If `push`: RAM[`wr_ptr`] <= `in_data`, then `wr_ptr`++.
  - If `refill`: `out_data` <= `mem_rdata`, `out_valid` <= 1, `rd_ptr`++.
  - Else if `pop`: `out_valid` <= 0, and `out_data` holds its value.
  - `mem_count` changes by +push − refill. Push and refill are mutually exclusive, so the net change is +1, −1 or 0.
- Reset or flush (reset wins if both are asserted):
  - `wr_ptr`, `rd_ptr` and `mem_count` go to 0; `out_valid` goes to 0.
  - Reset additionally clears `out_data` to 0; flush leaves `out_data` unchanged.
  - In-flight handshakes in that cycle are dropped: `in_ready`=0 and `mem_we`=0 are forced by flush. A pop completing in that cycle is still considered consumed.
- Boundaries:
  - **Full:** mem_count=64 gives `in_ready`=0 and `full`=1. `level` is 65 if `out_valid`=1.
  - **Empty:** mem_count=0 and `out_valid`=0 give `empty`=1. No RAM read occurs.
  - **Pointer equality:** `wr_ptr`==`rd_ptr` is ambiguous on its own; full versus empty is resolved only by `mem_count`.
- No overflow or underflow is possible through the handshake. Data pushed while `in_ready`=0 is ignored.

## Timing
- Reset values:
  - `in_ready`=1 (mem_count=0, so no refill).
  - `out_valid`=0, `out_data`=0, `level`=0, `full`=0, `empty`=1.
  - `mem_we`=0 unless `in_valid`=1.
  - `mem_addr`=0.
- Latency into an empty FIFO:
  - Push accepted at edge N.
  - Refill occurs in cycle N+1.
  - `out_valid`=1 after edge N+2.
  - Minimum is 2 cycles from the push edge to visibility.
- Throughput:
  - Continuous push with `out_ready`=1 alternates write and refill cycles, so sustained throughput is 0.5 word/cycle.
  - Bursts into a non-draining FIFO run at 1 word/cycle until full. Only the first refill steals one cycle.
- Order is strictly first-in, first-out, including across pointer wrap.

## Test plan
- **Reset/idle:** assert `reset` 2 cycles -> `out_valid`=0, `out_data`=0, `level`=0, `empty`=1, `in_ready`=1.
- **Single word:**
  - Push 16'hA5A5 at edge N -> `mem_we`=1, `mem_addr`=0 in cycle N.
  - In cycle N+1, refill drives `mem_addr`=0.
  - After edge N+2: `out_valid`=1, `out_data`=16'hA5A5, `level`=1.
  - Pop -> `empty`=1.
- **Fill to capacity:**
  - With `out_ready`=0, push 0..64.
  - Expect `level`=65, `full`=1, `in_ready`=0.
  - Further `in_valid` changes nothing.
  - Drain with `out_ready`=1 -> outputs 0..64 in order.
- **Wrap-around:** push 40, pop 40, then push/pop 100 words with random valid/ready -> sequence intact across 63->0, and `level` always matches the scoreboard.
- **Simultaneous:** `level`=3, `out_valid`=1, `in_valid`=1 and `out_ready`=1 in the same cycle -> refill wins, `in_ready`=0, `mem_we`=0. The push is accepted in a later cycle.
- **Flush mid-stream:** `level`=10, assert `flush` with `in_valid`=1 -> next cycle `level`=0, `out_valid`=0, and no RAM write in the flush cycle. A new push appears after 2 cycles.

Source files
------------

// File: rtl/ram64_fifo.sv
// ram64_fifo: valid/ready stream buffer built around the single-port ram64.
// Pointers, occupancy and a one-word registered head live here; the RAM holds
// the payload. Capacity is DEPTH words in RAM plus one in the head register.
// The RAM port serves one access per cycle, and a head refill (read) always
// takes the port ahead of a push (write).
module ram64_fifo #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(2**ADDR_W);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   mem_count;

  logic pop;
  logic refill;
  logic push;

  // Handshake decode; the head register reloads whenever it is empty or being taken.
  assign pop      = out_valid && out_ready;
  assign refill   = (mem_count != '0) && (!out_valid || pop) && !flush;
  assign in_ready = (mem_count != DEPTH_C) && !refill && !flush;
  assign push     = in_valid && in_ready;

  // RAM port: the read address wins the single port during a refill.
  assign mem_addr  = refill ? rd_ptr : wr_ptr;
  assign mem_we    = push;
  assign mem_wdata = in_data;

  // Status: the head register counts toward level but not toward full.
  assign level = mem_count + (ADDR_W+1)'(out_valid);
  assign full  = (mem_count == DEPTH_C);
  assign empty = (level == '0);

  // Pointer, occupancy and head-register update; reset also clears the head word.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_count <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_count <= '0;
      out_valid <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (refill) begin
        out_data  <= mem_rdata;
        out_valid <= 1'b1;
        rd_ptr    <= rd_ptr + ADDR_W'(1);
      end else if (pop) begin
        out_valid <= 1'b0;
      end
      case ({push, refill})
        2'b10:   mem_count <= mem_count + (ADDR_W+1)'(1);
        2'b01:   mem_count <= mem_count - (ADDR_W+1)'(1);
        default: mem_count <= mem_count;
      endcase
    end
  end

endmodule
